// File: rtl/i2c_target_if.sv
// Application-side handshake of the I2C target: received bytes, transmit requests and status.
interface i2c_target_if;
   logic       addressed;
   logic       rw;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic [7:0] tx_data;
   logic       tx_req;
   logic       nack_seen;

   modport slave (
      output addressed, rw, rx_data, rx_valid, tx_req, nack_seen,
      input  tx_data
   );

   modport master (
      input  addressed, rw, rx_data, rx_valid, tx_req, nack_seen,
      output tx_data
   );
endinterface

// File: rtl/i2c_target.sv
// I2C target (no clock stretching): oversampled SCL/SDA, 7-bit address match, byte write and read.
module i2c_target #(
   parameter logic [6:0] ADDR        = 7'h3C,
   parameter int         SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i2c_scl,
   inout  wire         i2c_sda,
   i2c_target_if.slave app
);
   typedef enum logic [2:0] {
      S_IDLE, S_ADDR, S_ADDR_ACK, S_WR_DATA, S_WR_ACK, S_RD_DATA, S_RD_ACK, S_WAIT_STOP
   } state_t;

   state_t                 state, state_nxt;
   logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
   logic                   scl_hist, sda_hist;
   logic [2:0]             cnt, cnt_nxt;
   logic [7:0]             shift, shift_nxt;
   logic                   sda_low, sda_low_nxt;
   logic                   load_pend, load_nxt;
   logic                   addressed, addressed_nxt;
   logic                   rw, rw_nxt;
   logic [7:0]             rx_data, rx_data_nxt;
   logic                   rx_valid, rx_valid_nxt;
   logic                   tx_req, tx_req_nxt;
   logic                   nack_seen, nack_nxt;

   logic scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;
   logic [7:0] byte_in;

   assign scl_s     = scl_sync[SYNC_STAGES-1];
   assign sda_s     = sda_sync[SYNC_STAGES-1];
   assign scl_rise  = scl_s & ~scl_hist;
   assign scl_fall  = ~scl_s & scl_hist;
   assign start_det = scl_s & scl_hist & sda_hist & ~sda_s;
   assign stop_det  = scl_s & scl_hist & ~sda_hist & sda_s;
   assign byte_in   = {shift[6:0], sda_s};

   assign i2c_sda       = sda_low ? 1'b0 : 1'bz;
   assign app.addressed = addressed;
   assign app.rw        = rw;
   assign app.rx_data   = rx_data;
   assign app.rx_valid  = rx_valid;
   assign app.tx_req    = tx_req;
   assign app.nack_seen = nack_seen;

   always_ff @(posedge clk) begin
      if (!rst) begin
         scl_sync  <= '1;
         sda_sync  <= '1;
         scl_hist  <= 1'b1;
         sda_hist  <= 1'b1;
         state     <= S_IDLE;
         cnt       <= 3'd0;
         shift     <= 8'h00;
         sda_low   <= 1'b0;
         load_pend <= 1'b0;
         addressed <= 1'b0;
         rw        <= 1'b0;
         rx_data   <= 8'h00;
         rx_valid  <= 1'b0;
         tx_req    <= 1'b0;
         nack_seen <= 1'b0;
      end else begin
         scl_sync[0] <= i2c_scl;
         sda_sync[0] <= i2c_sda;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            scl_sync[i] <= scl_sync[i-1];
            sda_sync[i] <= sda_sync[i-1];
         end
         scl_hist  <= scl_s;
         sda_hist  <= sda_s;
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         shift     <= shift_nxt;
         sda_low   <= sda_low_nxt;
         load_pend <= load_nxt;
         addressed <= addressed_nxt;
         rw        <= rw_nxt;
         rx_data   <= rx_data_nxt;
         rx_valid  <= rx_valid_nxt;
         tx_req    <= tx_req_nxt;
         nack_seen <= nack_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt;
      shift_nxt     = shift;
      sda_low_nxt   = sda_low;
      load_nxt      = 1'b0;
      addressed_nxt = addressed;
      rw_nxt        = rw;
      rx_data_nxt   = rx_data;
      rx_valid_nxt  = 1'b0;
      tx_req_nxt    = 1'b0;
      nack_nxt      = 1'b0;
      if (stop_det) begin
         state_nxt     = S_IDLE;
         sda_low_nxt   = 1'b0;
         addressed_nxt = 1'b0;
      end else if (start_det) begin
         state_nxt     = S_ADDR;
         sda_low_nxt   = 1'b0;
         addressed_nxt = 1'b0;
         cnt_nxt       = 3'd0;
      end else begin
         case (state)
            S_ADDR: if (scl_rise) begin
               shift_nxt = byte_in;
               cnt_nxt   = cnt + 3'd1;
               if (cnt == 3'd7) begin
                  if (byte_in[7:1] == ADDR && byte_in[7:1] != 7'h00) begin
                     state_nxt     = S_ADDR_ACK;
                     rw_nxt        = byte_in[0];
                     addressed_nxt = 1'b1;
                  end else begin
                     state_nxt = S_WAIT_STOP;
                  end
               end
            end
            // ACK slots: first SCL fall starts driving low, the next one ends the slot
            S_ADDR_ACK: if (scl_fall) begin
               if (!sda_low) begin
                  sda_low_nxt = 1'b1;
               end else if (rw) begin
                  state_nxt  = S_RD_DATA;
                  tx_req_nxt = 1'b1;
                  load_nxt   = 1'b1;
               end else begin
                  state_nxt   = S_WR_DATA;
                  sda_low_nxt = 1'b0;
                  cnt_nxt     = 3'd0;
               end
            end
            S_WR_DATA: if (scl_rise) begin
               shift_nxt = byte_in;
               cnt_nxt   = cnt + 3'd1;
               if (cnt == 3'd7) begin
                  rx_data_nxt  = byte_in;
                  rx_valid_nxt = 1'b1;
                  state_nxt    = S_WR_ACK;
               end
            end
            S_WR_ACK: if (scl_fall) begin
               if (!sda_low) begin
                  sda_low_nxt = 1'b1;
               end else begin
                  sda_low_nxt = 1'b0;
                  state_nxt   = S_WR_DATA;
                  cnt_nxt     = 3'd0;
               end
            end
            // cnt counts bits clocked out; it wraps to 0 after the eighth rising edge
            S_RD_DATA: begin
               if (load_pend) begin
                  shift_nxt   = app.tx_data;
                  sda_low_nxt = ~app.tx_data[7];
                  cnt_nxt     = 3'd0;
               end else if (scl_rise) begin
                  cnt_nxt = cnt + 3'd1;
               end else if (scl_fall) begin
                  if (cnt == 3'd0) begin
                     state_nxt   = S_RD_ACK;
                     sda_low_nxt = 1'b0;
                  end else begin
                     shift_nxt   = {shift[6:0], shift[7]};
                     sda_low_nxt = ~shift[6];
                  end
               end
            end
            S_RD_ACK: begin
               if (scl_rise && sda_s) begin
                  nack_nxt      = 1'b1;
                  addressed_nxt = 1'b0;
                  state_nxt     = S_WAIT_STOP;
               end else if (scl_fall) begin
                  state_nxt  = S_RD_DATA;
                  tx_req_nxt = 1'b1;
                  load_nxt   = 1'b1;
               end
            end
            S_IDLE, S_WAIT_STOP: ;
            default: state_nxt = S_IDLE;
         endcase
      end
   end
endmodule

// File: doc/i2c_target.md
I2C_TARGET -- requirements
Module: i2c_target

Interface
REQ-001 Parameter ADDR, default 7'h3C, is the 7-bit target address the block responds to.
REQ-002 Parameter SYNC_STAGES, default 2, is the number of synchroniser flops on SCL and SDA.
REQ-003 Port clk, input, 1 bit: system clock; all logic is on its rising edge.
REQ-004 Port rst, input, 1 bit: synchronous, active-low reset.
REQ-005 Port i2c_scl, input, 1 bit: bus clock from the initiator; the block never drives SCL (no clock stretching).
REQ-006 Port i2c_sda, inout, 1 bit: bus data; driven only to 0, otherwise high-Z.
REQ-007 Port addressed, output, 1 bit: high from address ACK until STOP, repeated START or read NACK.
REQ-008 Port rw, output, 1 bit: R/W bit of the current transaction (1 = read).
REQ-009 Port rx_data, output, 8 bits: last byte written by the initiator.
REQ-010 Port rx_valid, output, 1 bit: one-cycle pulse when rx_data updates.
REQ-011 Port tx_data, input, 8 bits: byte to return on a read.
REQ-012 Port tx_req, output, 1 bit: one-cycle pulse requesting the next tx_data.
REQ-013 Port nack_seen, output, 1 bit: one-cycle pulse when the initiator NACKs a read byte.

Function
REQ-014 SCL and SDA shall pass through SYNC_STAGES flops plus one history flop; edges shall be detected from the synchronised values only.
REQ-015 START is SDA 1->0 while SCL=1; STOP is SDA 0->1 while SCL=1.
REQ-016 Data bits shall be sampled on the detected SCL rising edge, MSB first.
REQ-017 SDA drive changes shall occur only in the cycle after a detected SCL falling edge.
REQ-018 FSM states: IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP.
REQ-019 IDLE -> ADDR on START; ADDR shifts 8 bits with a 3-bit counter.
REQ-020 In ADDR, after the 8th bit: on match with ADDR, go to ADDR_ACK and latch rw; otherwise go to WAIT_STOP with SDA released.
REQ-021 Address 7'h00 (general call) shall not be acknowledged.
REQ-022 ADDR_ACK shall drive SDA low for one SCL high period; addressed rises on entry to ADDR_ACK.
REQ-023 On the SCL falling edge ending ADDR_ACK: rw=0 goes to WR_DATA with SDA released; rw=1 goes to RD_DATA.
REQ-024 On entry to RD_DATA (from ADDR_ACK or RD_ACK on ACK), tx_req shall pulse and tx_data shall be loaded into the shift register one clk later; bit 7 is driven at that point.
REQ-025 WR_DATA: after the 8th rising edge, rx_data shall update and rx_valid shall pulse in the same cycle; then go to WR_ACK.
REQ-026 WR_ACK shall always ACK (SDA low); then return to WR_DATA.
REQ-027 RD_DATA: a 0 bit drives SDA low and a 1 bit releases it; after 8 bits SDA is released and the FSM goes to RD_ACK.
REQ-028 RD_ACK samples SDA on the rising edge: 0 (ACK) -> RD_DATA; 1 (NACK) -> pulse nack_seen, drop addressed, go to WAIT_STOP.
REQ-029 STOP in any state shall go to IDLE, release SDA and clear addressed.
REQ-030 START in any state (repeated START) shall go to ADDR, release SDA, clear addressed and reset the bit counter.
REQ-031 WAIT_STOP ignores data bits and leaves only on START or STOP.
REQ-032 Correct operation requires f_clk >= 16x f_SCL; no behaviour is guaranteed below that.

Reset
REQ-033 When rst=0 at a clk edge: state=IDLE, SDA released, addressed=0, rw=0, rx_data=8'h00, rx_valid=0, tx_req=0, nack_seen=0, counters=0, synchronisers=1.
REQ-034 A reset asserted mid-transfer shall release SDA on the next clk edge; the block then waits for a fresh START.

Verification
REQ-035 Write of 8'hA5 to 0x3C (100 kHz, clk 50 MHz) -> ACK on address and data; rx_valid pulses once; rx_data=8'hA5; rw=0.
REQ-036 Read from 0x3C with tx_data=8'h5A then 8'hC3, initiator ACK then NACK -> bus sees 5A, C3; tx_req pulses twice; nack_seen pulses once; addressed=0 afterwards.
REQ-037 Address 0x3D and then address 0x00 -> SDA never driven low; addressed stays 0; no rx_valid and no tx_req pulses.
REQ-038 Write 0x11, then repeated START, then read from 0x3C -> rx_data=8'h11; rw switches to 1; tx_req pulses after the second address ACK.
REQ-039 rst=0 while bit 3 of a read byte is driving SDA low -> SDA high-Z on the next clk edge; a subsequent clean write transaction completes normally.
REQ-040 STOP issued mid-byte during a write -> state IDLE; no rx_valid pulse; SDA released.
